// File: rtl/mem_access_ctrl_if.sv
// Bundle between mem_access_ctrl and its surroundings: the CPU request port, the
// program-load port and the Mem pins. slave = sequencer, master = everything around it.
interface mem_access_ctrl_if #(
   parameter int AW = 4,
   parameter int DW = 8
) ();
   logic          req;
   logic          rw;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic          ack;
   logic [DW-1:0] rdata;
   logic          busy;
   logic          load_start;
   logic          load_valid;
   logic [DW-1:0] load_data;
   logic          load_done;
   logic [AW-1:0] Mem_addr;
   logic [DW-1:0] Mem_wdata;
   logic [DW-1:0] Mem_rdata;
   logic          Mem_OE;
   logic          Mem_WE;
   logic          Mem_load;

   modport slave (
      input  req, rw, addr, wdata, load_start, load_valid, load_data, Mem_rdata,
      output ack, rdata, busy, load_done, Mem_addr, Mem_wdata, Mem_OE, Mem_WE, Mem_load
   );

   modport master (
      output req, rw, addr, wdata, load_start, load_valid, load_data, Mem_rdata,
      input  ack, rdata, busy, load_done, Mem_addr, Mem_wdata, Mem_OE, Mem_WE, Mem_load
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// Initiator-side sequencer for the 16x8 synchronous Mem: single read/write accesses with
// fixed latency plus a bulk program-load mode. Every output comes straight from a flop.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   IDLE     | waiting; load_start wins over req
//   WR       | Mem_WE strobe with latched addr/wdata
//   RD       | Mem_OE strobe with latched addr
//   RD_CAP   | Mem_out valid; captured into rdata at the end of this cycle
//   ACK      | ack pulse, then back to IDLE
//   LOAD     | streaming bytes to consecutive addresses from 0
//   LOAD_END | Mem_load strobe for the last address; load_done follows
module mem_access_ctrl #(
   parameter int AW = 4,
   parameter int DW = 8
) (
   input logic          CLK,
   input logic          RESET,
   mem_access_ctrl_if.slave bus
);

   typedef enum logic [2:0] {IDLE, WR, RD, RD_CAP, ACK, LOAD, LOAD_END} state_t;

   state_t        state, state_nxt;
   logic [AW-1:0] cnt, cnt_nxt;
   logic          ack_q, ack_nxt;
   logic          busy_q, busy_nxt;
   logic          done_q, done_nxt;
   logic          oe_q, oe_nxt;
   logic          we_q, we_nxt;
   logic          ld_q, ld_nxt;
   logic [DW-1:0] rdata_q, rdata_nxt;
   logic [AW-1:0] maddr_q, maddr_nxt;
   logic [DW-1:0] mwdata_q, mwdata_nxt;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state    <= IDLE;
         cnt      <= '0;
         ack_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         oe_q     <= 1'b0;
         we_q     <= 1'b0;
         ld_q     <= 1'b0;
         rdata_q  <= '0;
         maddr_q  <= '0;
         mwdata_q <= '0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         ack_q    <= ack_nxt;
         busy_q   <= busy_nxt;
         done_q   <= done_nxt;
         oe_q     <= oe_nxt;
         we_q     <= we_nxt;
         ld_q     <= ld_nxt;
         rdata_q  <= rdata_nxt;
         maddr_q  <= maddr_nxt;
         mwdata_q <= mwdata_nxt;
      end
   end

   // Outputs are the next-cycle values, so strobes line up with the state they belong to.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      ack_nxt    = 1'b0;
      done_nxt   = 1'b0;
      oe_nxt     = 1'b0;
      we_nxt     = 1'b0;
      ld_nxt     = 1'b0;
      rdata_nxt  = rdata_q;
      maddr_nxt  = maddr_q;
      mwdata_nxt = mwdata_q;
      case (state)
         IDLE: begin
            if (bus.load_start) begin
               state_nxt = LOAD;
               cnt_nxt   = '0;
            end else if (bus.req) begin
               maddr_nxt  = bus.addr;
               mwdata_nxt = bus.wdata;
               if (bus.rw) begin
                  state_nxt = WR;
                  we_nxt    = 1'b1;
               end else begin
                  state_nxt = RD;
                  oe_nxt    = 1'b1;
               end
            end
         end
         WR: begin
            state_nxt = ACK;
            ack_nxt   = 1'b1;
         end
         RD: state_nxt = RD_CAP;
         RD_CAP: begin
            state_nxt = ACK;
            ack_nxt   = 1'b1;
            rdata_nxt = bus.Mem_rdata;
         end
         ACK: state_nxt = IDLE;
         LOAD: begin
            if (bus.load_valid) begin
               ld_nxt     = 1'b1;
               maddr_nxt  = cnt;
               mwdata_nxt = bus.load_data;
               cnt_nxt    = cnt + 1'b1;
               if (cnt == '1) state_nxt = LOAD_END;
            end
         end
         LOAD_END: begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
      busy_nxt = (state_nxt != IDLE);
   end

   assign bus.ack       = ack_q;
   assign bus.rdata     = rdata_q;
   assign bus.busy      = busy_q;
   assign bus.load_done = done_q;
   assign bus.Mem_addr  = maddr_q;
   assign bus.Mem_wdata = mwdata_q;
   assign bus.Mem_OE    = oe_q;
   assign bus.Mem_WE    = we_q;
   assign bus.Mem_load  = ld_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural 16x8 registered-output Mem model.
module tb_mem_access_ctrl;

   logic CLK = 1'b0;
   logic RESET;
   int   n_chk = 0;
   int   n_fail = 0;

   mem_access_ctrl_if #(.AW(4), .DW(8)) bus ();

   mem_access_ctrl #(.AW(4), .DW(8)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   logic [7:0] mem [16];
   always @(posedge CLK) begin
      if (bus.Mem_WE || bus.Mem_load) mem[bus.Mem_addr] <= bus.Mem_wdata;
      if (bus.Mem_OE) bus.Mem_rdata <= mem[bus.Mem_addr];
   end

   int ack_cnt = 0, oe_cnt = 0, we_cnt = 0, done_cnt = 0, onehot_err = 0;
   always @(negedge CLK) begin
      if (!RESET) begin
         if (bus.ack) ack_cnt++;
         if (bus.Mem_OE) oe_cnt++;
         if (bus.Mem_WE) we_cnt++;
         if (bus.load_done) done_cnt++;
      end
      if (32'(bus.Mem_OE) + 32'(bus.Mem_WE) + 32'(bus.Mem_load) > 1) onehot_err++;
   end

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_write(input logic [3:0] a, input logic [7:0] d);
      int n;
      bus.req = 1'b1; bus.rw = 1'b1; bus.addr = a; bus.wdata = d;
      tick();
      chk_eq("wr_we", 32'(bus.Mem_WE), 32'd1);
      chk_eq("wr_addr", 32'(bus.Mem_addr), 32'(a));
      chk_eq("wr_data", 32'(bus.Mem_wdata), 32'(d));
      bus.req = 1'b0;
      n = 1;
      while (!bus.ack && n < 8) begin tick(); n++; end
      chk_eq("wr_ack_latency", 32'(n), 32'd2);
      chk_eq("wr_we_off", 32'(bus.Mem_WE), 32'd0);
      tick();
      chk_eq("wr_ack_pulse", 32'(bus.ack), 32'd0);
      chk_eq("wr_idle", 32'(bus.busy), 32'd0);
   endtask

   task automatic do_read(input logic [3:0] a, input logic [7:0] d);
      int n;
      bus.req = 1'b1; bus.rw = 1'b0; bus.addr = a;
      tick();
      chk_eq("rd_oe", 32'(bus.Mem_OE), 32'd1);
      chk_eq("rd_addr", 32'(bus.Mem_addr), 32'(a));
      bus.req = 1'b0;
      n = 1;
      while (!bus.ack && n < 8) begin tick(); n++; end
      chk_eq("rd_ack_latency", 32'(n), 32'd3);
      chk_eq("rd_data", 32'(bus.rdata), 32'(d));
      tick();
      chk_eq("rd_ack_pulse", 32'(bus.ack), 32'd0);
      chk_eq("rd_data_held", 32'(bus.rdata), 32'(d));
   endtask

   // Assumes the DUT is already in LOAD; returns in the load_done cycle.
   task automatic do_load_bytes(input logic [7:0] base, input bit gaps);
      for (int i = 0; i < 16; i++) begin
         if (gaps && (i % 3 == 1)) begin
            bus.load_valid = 1'b0;
            tick();
            chk_eq("load_gap", 32'(bus.Mem_load), 32'd0);
         end
         bus.load_valid = 1'b1;
         bus.load_data  = base + 8'(i);
         tick();
         chk_eq("load_strobe", 32'(bus.Mem_load), 32'd1);
         chk_eq("load_addr", 32'(bus.Mem_addr), 32'(i));
         chk_eq("load_data", 32'(bus.Mem_wdata), 32'(base + 8'(i)));
         chk_eq("load_no_done", 32'(bus.load_done), 32'd0);
      end
      bus.load_valid = 1'b1;
      bus.load_data  = 8'hEE;
      chk_eq("load_end_busy", 32'(bus.busy), 32'd1);
      tick();
      chk_eq("load_done", 32'(bus.load_done), 32'd1);
      chk_eq("load_done_nostrobe", 32'(bus.Mem_load), 32'd0);
      chk_eq("load_done_idle", 32'(bus.busy), 32'd0);
      bus.load_valid = 1'b0;
   endtask

   initial begin
      int a0, o0, w0, d0;
      RESET = 1'b1;
      bus.req = 1'b0; bus.rw = 1'b0; bus.addr = '0; bus.wdata = '0;
      bus.load_start = 1'b0; bus.load_valid = 1'b0; bus.load_data = '0;
      tick(); tick();
      chk_eq("rst_outputs", {8'(bus.rdata), 4'(bus.Mem_addr), 8'(bus.Mem_wdata), 6'd0,
             bus.ack, bus.busy, bus.load_done, bus.Mem_OE, bus.Mem_WE, bus.Mem_load}, 32'd0);
      RESET = 1'b0;
      tick();
      chk_eq("post_rst_busy", 32'(bus.busy), 32'd0);

      // 1, 2: basic write and read-back
      do_write(4'd5, 8'hA5);
      do_read(4'd5, 8'hA5);

      // 3: back-to-back load, then read the last address
      d0 = done_cnt;
      bus.load_start = 1'b1;
      tick();
      chk_eq("load_enter_busy", 32'(bus.busy), 32'd1);
      bus.load_start = 1'b0;
      do_load_bytes(8'h10, 1'b0);
      tick();
      chk_eq("load_done_pulse", 32'(bus.load_done), 32'd0);
      chk_eq("load_done_count", 32'(done_cnt - d0), 32'd1);
      do_read(4'd15, 8'h1F);
      do_read(4'd0, 8'h10);

      // 4: load with gaps, req held high throughout
      a0 = ack_cnt; o0 = oe_cnt;
      bus.load_start = 1'b1;
      tick();
      bus.load_start = 1'b0;
      bus.req = 1'b1; bus.rw = 1'b0; bus.addr = 4'd3;
      do_load_bytes(8'h40, 1'b1);
      chk_eq("load4_no_ack", 32'(ack_cnt - a0), 32'd0);
      chk_eq("load4_no_oe", 32'(oe_cnt - o0), 32'd0);
      tick();
      chk_eq("req_after_load_oe", 32'(bus.Mem_OE), 32'd1);
      chk_eq("req_after_load_addr", 32'(bus.Mem_addr), 32'd3);
      bus.req = 1'b0;
      tick(); tick();
      chk_eq("req_after_load_ack", 32'(bus.ack), 32'd1);
      chk_eq("req_after_load_data", 32'(bus.rdata), 32'h43);
      tick();

      // 5: load_start and req together -> load wins
      a0 = ack_cnt; o0 = oe_cnt; w0 = we_cnt;
      bus.req = 1'b1; bus.rw = 1'b1; bus.addr = 4'd7; bus.wdata = 8'h77;
      bus.load_start = 1'b1;
      tick();
      bus.req = 1'b0; bus.load_start = 1'b0;
      chk_eq("prio_busy", 32'(bus.busy), 32'd1);
      do_load_bytes(8'h80, 1'b0);
      chk_eq("prio_no_ack", 32'(ack_cnt - a0), 32'd0);
      chk_eq("prio_no_oe", 32'(oe_cnt - o0), 32'd0);
      chk_eq("prio_no_we", 32'(we_cnt - w0), 32'd0);
      tick();
      do_read(4'd7, 8'h87);

      // 6: reset during RD_CAP drops the read
      a0 = ack_cnt;
      bus.req = 1'b1; bus.rw = 1'b0; bus.addr = 4'd2;
      tick();
      bus.req = 1'b0;
      tick();
      RESET = 1'b1;
      tick();
      chk_eq("rst_mid_outputs", {8'(bus.rdata), 4'(bus.Mem_addr), 8'(bus.Mem_wdata), 6'd0,
             bus.ack, bus.busy, bus.load_done, bus.Mem_OE, bus.Mem_WE, bus.Mem_load}, 32'd0);
      RESET = 1'b0;
      tick(); tick(); tick();
      chk_eq("rst_mid_no_ack", 32'(ack_cnt - a0), 32'd0);
      do_write(4'd9, 8'h5C);
      do_read(4'd9, 8'h5C);
      do_read(4'd2, 8'h82);

      chk_eq("strobe_onehot", 32'(onehot_err), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
